// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl
//   Write-side pointer and full-flag controller for an asynchronous FIFO.
//   Everything in this module runs in the wclk domain.
//   - Keeps the binary write pointer, which also gives the memory write address.
//   - Publishes a registered Gray copy of that pointer for the read domain.
//   - Brings the read domain's Gray pointer across a plain flop chain.
//   - From these it derives full, almost_full, the fill level, a write
//     acknowledge and a sticky overflow flag.
//
// Ports
//   wclk          in   1        write clock
//   wrst_n        in   1        async active-low reset, removal synchronous to wclk
//   w_en          in   1        write request from the producer
//   clr_ovf       in   1        clears the overflow flag (a same-cycle set wins)
//   g_rptr_async  in   width+1  Gray read pointer from the rclk domain, unsynchronised
//   bw_ptr        out  width+1  binary write pointer; [width-1:0] is the memory address
//   g_wptr        out  width+1  registered Gray write pointer for the read-side synchroniser
//   full          out  1        FIFO full, registered
//   almost_full   out  1        fill level >= AF_THRESH, registered
//   wr_level      out  width+1  fill level 0..depth as seen from wclk (lags pops)
//   wr_ack        out  1        one-cycle pulse the cycle after an accepted write
//   overflow      out  1        sticky: a write was attempted while full
//
// Handshake: a write is accepted on a wclk edge when w_en=1 and full=0.
// The memory writes at bw_ptr[width-1:0] on that same edge. A write request
// made while full=1 is dropped and sets overflow instead.
module wptr_full_ctrl #(
  parameter int depth       = 8,
  parameter int width       = 3,
  parameter int AF_THRESH   = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic           wclk,
  input  logic           wrst_n,
  input  logic           w_en,
  input  logic           clr_ovf,
  input  logic [width:0] g_rptr_async,
  output logic [width:0] bw_ptr,
  output logic [width:0] g_wptr,
  output logic           full,
  output logic           almost_full,
  output logic [width:0] wr_level,
  output logic           wr_ack,
  output logic           overflow
);

  localparam logic [width:0] AF_LVL = AF_THRESH[width:0];
  localparam logic [width:0] DEPTH  = depth[width:0];

  logic [width:0] sync_q [SYNC_STAGES];
  logic [width:0] rq;
  logic [width:0] rbin;
  logic [width:0] bnext;
  logic [width:0] gnext;
  logic [width:0] fill;
  logic           push;

  // The synchroniser is a bare flop chain. Keep all logic out of it so that
  // each stage has the full cycle to settle out of metastability.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= g_rptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq = sync_q[SYNC_STAGES-1];

  // Convert Gray to binary: each binary bit is the XOR of all Gray bits at
  // that position and above.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= width; i++) rbin[i] = ^(rq >> i);
  end

  assign push  = w_en & ~full;
  assign bnext = bw_ptr + {{width{1'b0}}, push};
  assign gnext = (bnext >> 1) ^ bnext;

  // The fill level is measured against a read pointer that is already a few
  // cycles old. It can therefore only overestimate the occupancy, so it is
  // safe to use for flow control.
  assign fill  = bnext - rbin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      bw_ptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      wr_ack      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      bw_ptr      <= bnext;
      g_wptr      <= gnext;
      // The FIFO is full when the write pointer is exactly one lap ahead of
      // the read pointer. In Gray code this means the top two bits are
      // inverted and the remaining bits match.
      full        <= (gnext == {~rq[width:width-1], rq[width-2:0]});
      almost_full <= (fill >= AF_LVL);
      wr_level    <= (fill > DEPTH) ? DEPTH : fill;
      wr_ack      <= push;
      // If set and clear arrive together, set wins, so a drop is never lost.
      if (w_en && full)  overflow <= 1'b1;
      else if (clr_ovf)  overflow <= 1'b0;
    end
  end

endmodule
